// File: rtl/cam_ins_ctrl.sv
// Insert/invalidate controller for one read and one write port of the team CAM.
// Define CAM_INS_EVICT_EN to evict a round-robin victim on a full CAM.
module cam_ins_ctrl #(
   parameter int unsigned KEY   = 15,
   parameter int unsigned DEPTH = 64,
   parameter int unsigned ADDR  = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            reset_,
   input  logic            ins_req_,
   input  logic [KEY-1:0]  ins_key,
   input  logic            inv_req_,
   input  logic [ADDR-1:0] inv_addr,
   output logic            ready,
   output logic            done,
   output logic            done_hit,
   output logic            done_full,
   output logic [ADDR-1:0] done_addr,
   output logic [ADDR:0]   occupancy,
   output logic            cam_re_,
   output logic [KEY:0]    cam_rd,
   output logic [KEY:0]    cam_rm,
   input  logic            cam_match,
   input  logic [ADDR-1:0] cam_raddr,
   output logic            cam_we_,
   output logic [KEY:0]    cam_wd,
   output logic [KEY:0]    cam_wm,
   output logic [ADDR-1:0] cam_waddr
);

   typedef enum logic [2:0] {
      StIdle,
      StLook,
      StDec,
      StWr,
      StInv,
      StRsp
   } state_e;

   localparam logic [ADDR:0] FullCnt = (ADDR+1)'(DEPTH);

   state_e          state_q, state_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [KEY-1:0]  key_q, key_d;
   logic [ADDR-1:0] addr_q, addr_d;
   logic            match_q, match_d;
   logic [ADDR-1:0] raddr_q, raddr_d;
   logic [ADDR:0]   occ_q, occ_d;
   logic            ready_q, ready_d;
   logic            done_q, done_d;
   logic            done_hit_q, done_hit_d;
   logic            done_full_q, done_full_d;
   logic [ADDR-1:0] done_addr_q, done_addr_d;
   logic            cam_re_q, cam_re_d;
   logic            cam_we_q, cam_we_d;
   logic [KEY:0]    cam_wd_q, cam_wd_d;
   logic [ADDR-1:0] cam_waddr_q, cam_waddr_d;

   logic            free_found;
   logic [ADDR-1:0] free_idx;

`ifdef CAM_INS_EVICT_EN
   logic [ADDR-1:0] rr_q, rr_d;
`endif

   // Lowest-index invalid entry.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = ADDR'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      key_d   = key_q;
      addr_d  = addr_q;
      match_d = match_q;
      raddr_d = raddr_q;
      occ_d   = occ_q;
`ifdef CAM_INS_EVICT_EN
      rr_d    = rr_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (!inv_req_) begin
               addr_d  = inv_addr;
               state_d = StInv;
            end else if (!ins_req_) begin
               key_d   = ins_key;
               state_d = StLook;
            end
         end
         StLook: begin
            match_d = cam_match;
            raddr_d = cam_raddr;
            state_d = StDec;
         end
         StDec: begin
            if (match_q) begin
               addr_d  = raddr_q;
               state_d = StRsp;
            end else if (free_found) begin
               addr_d  = free_idx;
               state_d = StWr;
            end else begin
`ifdef CAM_INS_EVICT_EN
               addr_d  = rr_q;
               rr_d    = (rr_q == ADDR'(DEPTH - 1)) ? '0 : rr_q + 1'b1;
               state_d = StWr;
`else
               addr_d  = '0;
               state_d = StRsp;
`endif
            end
         end
         StWr: begin
            valid_d[addr_q] = 1'b1;
            if (!valid_q[addr_q] && occ_q < FullCnt) begin
               occ_d = occ_q + 1'b1;
            end
            state_d = StRsp;
         end
         StInv: begin
            valid_d[addr_q] = 1'b0;
            if (valid_q[addr_q] && occ_q != '0) begin
               occ_d = occ_q - 1'b1;
            end
            state_d = StIdle;
         end
         StRsp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet aligned to it.
   always_comb begin
      ready_d     = (state_d == StIdle);
      done_d      = (state_d == StRsp);
      done_hit_d  = (state_d == StRsp) && match_q;
      done_full_d = (state_d == StRsp) && (state_q == StDec) && !match_q;
      done_addr_d = (state_d == StRsp) ? addr_d : '0;
      cam_re_d    = (state_d != StLook);
      cam_we_d    = !((state_d == StWr) || (state_d == StInv));
      cam_wd_d    = (state_d == StWr) ? {1'b1, key_d} : '0;
      cam_waddr_d = addr_d;
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         state_q     <= StIdle;
         valid_q     <= '0;
         key_q       <= '0;
         addr_q      <= '0;
         match_q     <= 1'b0;
         raddr_q     <= '0;
         occ_q       <= '0;
         ready_q     <= 1'b1;
         done_q      <= 1'b0;
         done_hit_q  <= 1'b0;
         done_full_q <= 1'b0;
         done_addr_q <= '0;
         cam_re_q    <= 1'b1;
         cam_we_q    <= 1'b1;
         cam_wd_q    <= '0;
         cam_waddr_q <= '0;
`ifdef CAM_INS_EVICT_EN
         rr_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         key_q       <= key_d;
         addr_q      <= addr_d;
         match_q     <= match_d;
         raddr_q     <= raddr_d;
         occ_q       <= occ_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
         done_hit_q  <= done_hit_d;
         done_full_q <= done_full_d;
         done_addr_q <= done_addr_d;
         cam_re_q    <= cam_re_d;
         cam_we_q    <= cam_we_d;
         cam_wd_q    <= cam_wd_d;
         cam_waddr_q <= cam_waddr_d;
`ifdef CAM_INS_EVICT_EN
         rr_q        <= rr_d;
`endif
      end
   end

   assign ready     = ready_q;
   assign done      = done_q;
   assign done_hit  = done_hit_q;
   assign done_full = done_full_q;
   assign done_addr = done_addr_q;
   assign occupancy = occ_q;
   assign cam_re_   = cam_re_q;
   assign cam_rd    = {1'b1, key_q};
   assign cam_rm    = '0;
   assign cam_we_   = cam_we_q;
   assign cam_wd    = cam_wd_q;
   assign cam_wm    = '0;
   assign cam_waddr = cam_waddr_q;

endmodule
